// File: rtl/va_pkg.sv
// ---------------------------------------------------------------------------
// va_pkg
// Shared definitions for the virtual-channel allocator slice.
//   - DEFAULT_N_OF_REQUEST / DEFAULT_N_OF_VC : default sizing of one VN
//   - clog2 : ceiling log2, used to validate index-width parameters
//   - ff1   : find-first-one (lowest set bit) over a 32-bit vector
// No ports; imported with "import va_pkg::*;".
// ---------------------------------------------------------------------------
package va_pkg;

   localparam int DEFAULT_N_OF_REQUEST = 6;
   localparam int DEFAULT_N_OF_VC      = 2;

   // Returned by ff1 when the vector has no bit set.
   localparam int FF1_NONE = 32;

   // Ceiling log2; clog2(1) = 0. Only used at elaboration time.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

   // Index of the lowest set bit, FF1_NONE when the vector is empty.
   function automatic int ff1(input logic [31:0] vec);
      int idx;
      idx = FF1_NONE;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/va_vn_multi_grant_rr_multi_pick.sv
// ---------------------------------------------------------------------------
// rr_multi_pick
// Purely combinational round-robin multi-grant picker. Scans the requesters
// starting one past the last served index, wrapping, and gives each eligible
// requester the lowest-index free VC not yet handed out this cycle. Stops
// after MAX_GRANTS grants or when no VC is left.
// Ports:
//   req         in  [N_OF_REQUEST]          eligible requesters
//   vc_free     in  [N_OF_VC]               VCs available for allocation
//   last_served in  [N_BITS_N_OF_REQUEST]   round-robin pointer
//   grant_req   out [N_OF_REQUEST]          winners of this cycle
//   grant_vc    out [N_OF_REQUEST*N_OF_VC]  one-hot VC per winner
//   next_ptr    out [N_BITS_N_OF_REQUEST]   last winner in scan order
//   grant_any   out                         at least one grant issued
// ---------------------------------------------------------------------------
module rr_multi_pick
   import va_pkg::*;
#(
   parameter int N_OF_REQUEST        = DEFAULT_N_OF_REQUEST,
   parameter int N_BITS_N_OF_REQUEST = 3,
   parameter int N_OF_VC             = DEFAULT_N_OF_VC,
   parameter int MAX_GRANTS          = 2
) (
   input  logic [N_OF_REQUEST-1:0]         req,
   input  logic [N_OF_VC-1:0]              vc_free,
   input  logic [N_BITS_N_OF_REQUEST-1:0]  last_served,
   output logic [N_OF_REQUEST-1:0]         grant_req,
   output logic [N_OF_REQUEST*N_OF_VC-1:0] grant_vc,
   output logic [N_BITS_N_OF_REQUEST-1:0]  next_ptr,
   output logic                            grant_any
);

   // The wrap is an explicit modulo on integer positions so requester counts
   // that are not a power of two still visit every position exactly once.
   // avail shrinks as VCs are handed out, which keeps winners on distinct VCs.
   always_comb begin
      logic [N_OF_VC-1:0] avail;
      int                 n_granted;
      int                 pos;
      int                 v;
      avail     = vc_free;
      n_granted = 0;
      pos       = 0;
      v         = 0;
      grant_req = '0;
      grant_vc  = '0;
      next_ptr  = last_served;
      grant_any = 1'b0;
      for (int k = 0; k < N_OF_REQUEST; k++) begin
         pos = (int'(last_served) + 1 + k) % N_OF_REQUEST;
         if (req[pos] && (avail != '0) && (n_granted < MAX_GRANTS)) begin
            v                            = ff1(32'(avail));
            avail[v]                     = 1'b0;
            grant_req[pos]               = 1'b1;
            grant_vc[pos*N_OF_VC + v]    = 1'b1;
            next_ptr                     = N_BITS_N_OF_REQUEST'(pos);
            grant_any                    = 1'b1;
            n_granted                    = n_granted + 1;
         end
      end
   end

endmodule

// File: rtl/va_vn_multi_grant.sv
// ---------------------------------------------------------------------------
// va_vn_multi_grant
// Virtual-channel allocator for one virtual network. Grants up to MAX_GRANTS
// (requester, VC) pairs per cycle, round-robin over requesters, and keeps a
// granted VC busy until the downstream side releases it.
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   r_va_vn_i      in   [N_OF_REQUEST]          level request per requester
//   vc_release_i   in   [N_OF_VC]               release pulse per VC
//   g_va_vn_o      out  [N_OF_REQUEST]          grant per requester
//   g_vc_o         out  [N_OF_REQUEST*N_OF_VC]  one-hot VC slice per requester
//   vc_free_o      out  [N_OF_VC]               registered VC free status
//   owner_valid_o  out  [N_OF_REQUEST]          requester holds a VC
// Build option: define VA_VN_OUTPUT_REG_EN to register g_va_vn_o/g_vc_o,
// delaying grants by one cycle; internal state timing is unchanged.
// ---------------------------------------------------------------------------
module va_vn_multi_grant
   import va_pkg::*;
#(
   parameter int N_OF_REQUEST        = DEFAULT_N_OF_REQUEST,
   parameter int N_BITS_N_OF_REQUEST = 3,
   parameter int N_OF_VC             = DEFAULT_N_OF_VC,
   parameter int N_BITS_VC           = 1,
   parameter int MAX_GRANTS          = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_OF_REQUEST-1:0]         r_va_vn_i,
   input  logic [N_OF_VC-1:0]              vc_release_i,
   output logic [N_OF_REQUEST-1:0]         g_va_vn_o,
   output logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_o,
   output logic [N_OF_VC-1:0]              vc_free_o,
   output logic [N_OF_REQUEST-1:0]         owner_valid_o
);

   // Reject configurations whose index widths cannot hold every index.
   localparam int MIN_BITS_VC = (clog2(N_OF_VC) > 1) ? clog2(N_OF_VC) : 1;

   if (N_BITS_N_OF_REQUEST < clog2(N_OF_REQUEST)) begin : g_bad_req_bits
      $error("N_BITS_N_OF_REQUEST too small for N_OF_REQUEST");
   end
   if (N_BITS_VC < MIN_BITS_VC) begin : g_bad_vc_bits
      $error("N_BITS_VC too small for N_OF_VC");
   end
   if ((MAX_GRANTS < 1) || (MAX_GRANTS > N_OF_VC)) begin : g_bad_max_grants
      $error("MAX_GRANTS must lie in 1..N_OF_VC");
   end

   logic [N_OF_VC-1:0]              vc_free_r;
   logic [N_BITS_N_OF_REQUEST-1:0]  vc_owner_r [N_OF_VC];
   logic [N_OF_REQUEST-1:0]         owner_valid_r;
   logic [N_BITS_N_OF_REQUEST-1:0]  last_served_r;

   logic [N_OF_REQUEST-1:0]         eligible;
   logic [N_OF_REQUEST-1:0]         pick_req;
   logic [N_OF_REQUEST*N_OF_VC-1:0] pick_vc;
   logic [N_BITS_N_OF_REQUEST-1:0]  pick_ptr;
   logic                            pick_any;

   // A requester that already owns a VC is masked, so it can hold its request
   // high without collecting a second VC.
   assign eligible = r_va_vn_i & ~owner_valid_r;

   rr_multi_pick #(
      .N_OF_REQUEST        (N_OF_REQUEST),
      .N_BITS_N_OF_REQUEST (N_BITS_N_OF_REQUEST),
      .N_OF_VC             (N_OF_VC),
      .MAX_GRANTS          (MAX_GRANTS)
   ) u_pick (
      .req         (eligible),
      .vc_free     (vc_free_r),
      .last_served (last_served_r),
      .grant_req   (pick_req),
      .grant_vc    (pick_vc),
      .next_ptr    (pick_ptr),
      .grant_any   (pick_any)
   );

   // Ownership bookkeeping. Releases only act on busy VCs, and grants only
   // take free VCs, so the two loops never touch the same VC in one cycle.
   // A released owner cannot be a winner in the same cycle either, because
   // it was masked by owner_valid_r when the grant was computed.
   always_ff @(posedge clk) begin
      if (rst) begin
         vc_free_r     <= '1;
         owner_valid_r <= '0;
         last_served_r <= N_BITS_N_OF_REQUEST'(N_OF_REQUEST - 1);
         for (int v = 0; v < N_OF_VC; v++) begin
            vc_owner_r[v] <= '0;
         end
      end else begin
         for (int v = 0; v < N_OF_VC; v++) begin
            if (vc_release_i[v] && !vc_free_r[v]) begin
               vc_free_r[v]                 <= 1'b1;
               owner_valid_r[vc_owner_r[v]] <= 1'b0;
            end
         end
         for (int r = 0; r < N_OF_REQUEST; r++) begin
            for (int v = 0; v < N_OF_VC; v++) begin
               if (pick_vc[r*N_OF_VC + v]) begin
                  vc_free_r[v]     <= 1'b0;
                  vc_owner_r[v]    <= N_BITS_N_OF_REQUEST'(r);
                  owner_valid_r[r] <= 1'b1;
               end
            end
         end
         if (pick_any) begin
            last_served_r <= pick_ptr;
         end
      end
   end

   assign vc_free_o     = vc_free_r;
   assign owner_valid_o = owner_valid_r;

`ifdef VA_VN_OUTPUT_REG_EN
   logic [N_OF_REQUEST-1:0]         g_va_vn_r;
   logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_r;

   // Grants are captured at the same edge that commits ownership, so they
   // surface one cycle after the request cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         g_va_vn_r <= '0;
         g_vc_r    <= '0;
      end else begin
         g_va_vn_r <= pick_req;
         g_vc_r    <= pick_vc;
      end
   end

   // Gating with rst keeps the grant outputs quiet for the whole reset cycle,
   // not only from the edge after it.
   assign g_va_vn_o = rst ? '0 : g_va_vn_r;
   assign g_vc_o    = rst ? '0 : g_vc_r;
`else
   assign g_va_vn_o = rst ? '0 : pick_req;
   assign g_vc_o    = rst ? '0 : pick_vc;
`endif

endmodule
